// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 sprite blitter.
// Optional build macro: CHIP8_WRAP_EN (wrap off-screen pixels instead of clipping).
package chip8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAW,
    DONE
  } state_t;

  localparam int DEF_DISP_W = 64;
  localparam int DEF_DISP_H = 32;
  localparam int DEF_ADDR_W = 12;

  localparam int SPRITE_BITS = 8;
  localparam int MAX_ROWS    = 15;

endpackage

// File: rtl/chip8_blit_row.sv
// One display row XORed with one sprite byte, plus the collision bit for that row.
// Optional build macro: CHIP8_WRAP_EN (columns past the right edge wrap to column 0
// and still collide); without it those columns are clipped.
module chip8_blit_row
  import chip8_pkg::*;
#(
  parameter int DISP_W = DEF_DISP_W
) (
  input  logic [DISP_W-1:0]         row_in,
  input  logic [$clog2(DISP_W)-1:0] x0,
  input  logic [SPRITE_BITS-1:0]    sprite,
  input  logic                      row_valid,
  output logic [DISP_W-1:0]         row_out,
  output logic                      hit
);

  localparam int XW = $clog2(DISP_W);
  localparam int CW = XW + 1;

  logic [CW-1:0] col;

  // Walk the eight sprite bits (MSB = leftmost), toggling and collision-testing each drawn pixel
  always_comb begin
    row_out = row_in;
    hit     = 1'b0;
    col     = '0;
    for (int i = 0; i < SPRITE_BITS; i++) begin
      col = {1'b0, x0} + CW'(i);
`ifdef CHIP8_WRAP_EN
      if (row_valid && sprite[SPRITE_BITS-1-i]) begin
`else
      if (row_valid && sprite[SPRITE_BITS-1-i] && !col[XW]) begin
`endif
        hit                  = hit | row_in[col[XW-1:0]];
        row_out[col[XW-1:0]] = ~row_in[col[XW-1:0]];
      end
    end
  end

endmodule

// File: rtl/chip8_sprite_blit.sv
// CHIP-8 DXYN sprite-draw engine: FSM, framebuffer and memory read sequencing.
// Optional build macro: CHIP8_WRAP_EN (rows past the bottom edge wrap to row 0
// instead of being clipped; column handling lives in chip8_blit_row).
module chip8_sprite_blit
  import chip8_pkg::*;
#(
  parameter int DISP_W = DEF_DISP_W,
  parameter int DISP_H = DEF_DISP_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic [7:0]               x_in,
  input  logic [7:0]               y_in,
  input  logic [3:0]               n_in,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     collision,
  output logic [DISP_W*DISP_H-1:0] display
);

  localparam int XW  = $clog2(DISP_W);
  localparam int YW  = $clog2(DISP_H);
  localparam int YSW = YW + 1;

  state_t              state;
  logic [XW-1:0]       x0;
  logic [YW-1:0]       y0;
  logic [3:0]          n_reg;
  logic [ADDR_W-1:0]   i_reg;
  logic [3:0]          row;
  logic [3:0]          row_next;
  logic                acc;

  logic [DISP_W-1:0]   fb [DISP_H];

  logic [YSW-1:0]      y_sum;
  logic [YW-1:0]       y_idx;
  logic                row_valid;
  logic [DISP_W-1:0]   new_row;
  logic                hit;

  // Target row of the current sprite line and whether it lands on screen
  always_comb begin
    y_sum    = {1'b0, y0} + YSW'(row);
    y_idx    = y_sum[YW-1:0];
    row_next = row + 4'd1;
`ifdef CHIP8_WRAP_EN
    row_valid = 1'b1;
`else
    row_valid = !y_sum[YW];
`endif
  end

  chip8_blit_row #(
    .DISP_W(DISP_W)
  ) u_row (
    .row_in   (fb[y_idx]),
    .x0       (x0),
    .sprite   (mem_rdata),
    .row_valid(row_valid),
    .row_out  (new_row),
    .hit      (hit)
  );

  for (genvar g = 0; g < DISP_H; g++) begin : g_disp
    assign display[g*DISP_W +: DISP_W] = fb[g];
  end

  // Draw sequencer: one READ/DRAW pair per sprite row, then a one-cycle DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      x0        <= '0;
      y0        <= '0;
      n_reg     <= '0;
      i_reg     <= '0;
      row       <= '0;
      acc       <= 1'b0;
      for (int r = 0; r < DISP_H; r++) fb[r] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (clear) begin
            for (int r = 0; r < DISP_H; r++) fb[r] <= '0;
          end else if (start) begin
            x0        <= x_in[XW-1:0];
            y0        <= y_in[YW-1:0];
            n_reg     <= n_in;
            i_reg     <= i_addr;
            row       <= '0;
            acc       <= 1'b0;
            collision <= 1'b0;
            busy      <= 1'b1;
            if (n_in != 4'd0) begin
              state     <= READ;
              mem_rd_en <= 1'b1;
              mem_addr  <= i_addr;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          mem_rd_en <= 1'b0;
          state     <= DRAW;
        end
        DRAW: begin
          if (row_valid) fb[y_idx] <= new_row;
          acc <= acc | hit;
          row <= row_next;
          if (row_next < n_reg) begin
            state     <= READ;
            mem_rd_en <= 1'b1;
            mem_addr  <= i_reg + ADDR_W'(row_next);
          end else begin
            state     <= DONE;
            done      <= 1'b1;
            collision <= acc | hit;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_sprite_blit.sv
// Scoreboard bench for chip8_sprite_blit (64x32, 12-bit addresses).
// Build with CHIP8_WRAP_EN defined to check the wrapping variant of the corner draw.
module tb_chip8_sprite_blit;

  localparam int W    = 64;
  localparam int H    = 32;
  localparam int AW   = 12;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            clear = 1'b0;
  logic [7:0]      x_in = '0;
  logic [7:0]      y_in = '0;
  logic [3:0]      n_in = '0;
  logic [AW-1:0]   i_addr = '0;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_rdata = '0;
  logic            busy;
  logic            done;
  logic            collision;
  logic [NPIX-1:0] display;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [4096];

  typedef struct {
    string           name;
    logic            coll;
    logic [NPIX-1:0] disp;
    int              lat;
    int              c0;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];

  chip8_sprite_blit #(
    .DISP_W(W),
    .DISP_H(H),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .x_in     (x_in),
    .y_in     (y_in),
    .n_in     (n_in),
    .i_addr   (i_addr),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .collision(collision),
    .display  (display)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc = cyc + 1;

  // Synchronous-read byte memory
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkDisplay(input string name, input logic [NPIX-1:0] act, input logic [NPIX-1:0] exp);
    int ndiff;
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      ndiff = 0;
      first = -1;
      for (int k = 0; k < NPIX; k++) begin
        if (act[k] !== exp[k]) begin
          ndiff++;
          if (first < 0) first = k;
        end
      end
      $display("[TB] FAIL %s: display differs in %0d pixels, first at x=%0d y=%0d (got %b expected %b)",
               name, ndiff, first % W, first / W, act[first], exp[first]);
    end
  endtask

  function automatic logic [NPIX-1:0] px(input logic [NPIX-1:0] d, input int x, input int y);
    d[y*W+x] = 1'b1;
    return d;
  endfunction

  // Done monitor: pops the next expected draw result whenever done is seen
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected done: got done=1 expected no completion");
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, " collision"}, 32'(collision), 32'(e.coll));
        checkDisplay({e.name, " display"}, display, e.disp);
        checkOutput({e.name, " latency"}, 32'(cyc - e.c0 + 1), 32'(e.lat));
      end
    end
  end

  // Read monitor: every memory strobe must match the next expected address
  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected read: got addr %0h expected no read", mem_addr);
      end else begin
        checkOutput("read addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [7:0] x, input logic [7:0] y,
                               input logic [3:0] n, input logic [AW-1:0] i,
                               input logic exp_coll, input logic [NPIX-1:0] exp_disp);
    exp_t e;
    logic [AW-1:0] a;
    @(negedge clk);
    for (int r = 0; r < int'(n); r++) begin
      a = i + AW'(r);
      addr_q.push_back(a);
    end
    x_in   = x;
    y_in   = y;
    n_in   = n;
    i_addr = i;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    e.name = name;
    e.coll = exp_coll;
    e.disp = exp_disp;
    e.lat  = 2 * int'(n) + 1;
    e.c0   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, " returns idle"}, 32'(busy), 32'd0);
  endtask

  task automatic doClear(input string name);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkDisplay(name, display, '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NPIX-1:0] font0;
    logic [NPIX-1:0] corner;
    logic [NPIX-1:0] modulo;
    logic [NPIX-1:0] wrapd;

    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    mem[12'h050] = 8'hF0;
    mem[12'h051] = 8'h90;
    mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90;
    mem[12'h054] = 8'hF0;
    mem[12'h300] = 8'hFF;
    mem[12'h301] = 8'h80;
    mem[12'hFFE] = 8'h81;
    mem[12'hFFF] = 8'h42;
    mem[12'h000] = 8'h24;

    font0 = '0;
    for (int x = 0; x < 4; x++) begin
      font0 = px(font0, x, 0);
      font0 = px(font0, x, 4);
    end
    for (int y = 1; y < 4; y++) begin
      font0 = px(font0, 0, y);
      font0 = px(font0, 3, y);
    end

    corner = '0;
    corner = px(corner, 62, 31);
    corner = px(corner, 63, 31);
`ifdef CHIP8_WRAP_EN
    for (int x = 0; x < 6; x++) corner = px(corner, x, 31);
`endif

    modulo = px('0, 6, 8);

    wrapd = '0;
    wrapd = px(wrapd, 8, 10);
    wrapd = px(wrapd, 15, 10);
    wrapd = px(wrapd, 9, 11);
    wrapd = px(wrapd, 14, 11);
    wrapd = px(wrapd, 10, 12);
    wrapd = px(wrapd, 13, 12);

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset collision", 32'(collision), 32'd0);
    checkOutput("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkDisplay("reset display", display, '0);
    reset = 1'b0;

    $display("[TB] font 0 draw and erase");
    applyStimulus("font0", 8'd0, 8'd0, 4'd5, 12'h050, 1'b0, font0);
    waitIdle("font0");
    applyStimulus("font0 again", 8'd0, 8'd0, 4'd5, 12'h050, 1'b1, '0);
    waitIdle("font0 again");

    $display("[TB] zero-row draw");
    applyStimulus("n0", 8'd0, 8'd0, 4'd0, 12'h123, 1'b0, '0);
    waitIdle("n0");

    $display("[TB] bottom-right corner");
    applyStimulus("corner", 8'd62, 8'd31, 4'd1, 12'h300, 1'b0, corner);
    waitIdle("corner");
    doClear("clear after corner");

    $display("[TB] start coordinate modulo");
    applyStimulus("modulo", 8'd70, 8'd40, 4'd1, 12'h301, 1'b0, modulo);
    waitIdle("modulo");
    doClear("clear after modulo");

    $display("[TB] address wrap with start while busy");
    applyStimulus("addr wrap", 8'd8, 8'd10, 4'd3, 12'hFFE, 1'b0, wrapd);
    @(negedge clk);
    x_in   = 8'd0;
    y_in   = 8'd0;
    n_in   = 4'd5;
    i_addr = 12'h050;
    start  = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    clear  = 1'b0;
    checkOutput("busy during draw", 32'(busy), 32'd1);
    waitIdle("addr wrap");

    $display("[TB] start and clear together");
    @(negedge clk);
    x_in   = 8'd1;
    y_in   = 8'd1;
    n_in   = 4'd1;
    i_addr = 12'h300;
    start  = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    clear  = 1'b0;
    checkOutput("start+clear busy", 32'(busy), 32'd0);
    checkDisplay("start+clear display", display, '0);
    repeat (4) @(negedge clk);
    checkOutput("start+clear stays idle", 32'(busy), 32'd0);

    $display("[TB] reset mid-draw");
    @(negedge clk);
    x_in   = 8'd0;
    y_in   = 8'd0;
    n_in   = 4'd5;
    i_addr = 12'h050;
    addr_q.push_back(12'h050);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("pre-reset row0", 32'(display[3:0]), 32'hF);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    checkOutput("mid reset mem_rd_en", 32'(mem_rd_en), 32'd0);
    checkDisplay("mid reset display", display, '0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("post reset busy", 32'(busy), 32'd0);

    checkOutput("pending done results", 32'(exp_q.size()), 32'd0);
    checkOutput("pending reads", 32'(addr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
